// File: rtl/gcd_lcm_cop.sv
// gcd_lcm_cop: multi-cycle GCD (binary Stein) / LCM coprocessor.
// LCM is formed as (op_a / gcd) * op_b: restoring division, then shift-add multiply.
module gcd_lcm_cop #(
    parameter int WIDTH  = 32,
    parameter int LCM_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             overflow
);
    localparam int KW = $clog2(WIDTH + 1);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_GCD, S_DIV, S_MUL, S_DONE} state_e;

    state_e             state_q, state_d;
    logic               lcm_q;
    logic [WIDTH-1:0]   opa_q, opb_q;
    logic [WIDTH-1:0]   a_q, b_q, g_q;
    logic [KW-1:0]      k_q;
    logic [WIDTH-1:0]   result_q, result_hi_q;
    logic               overflow_q;

    logic               accept, zero_case, gcd_fin, to_div, div_fin, mul_fin;
    logic [WIDTH-1:0]   g_val;
    logic [2*WIDTH-1:0] lcm_prod;

    assign accept    = start && (state_q == S_IDLE || state_q == S_DONE);
    assign zero_case = (a_q == '0) || (b_q == '0);
    assign gcd_fin   = (state_q == S_GCD) && (zero_case || a_q == b_q);
    assign to_div    = lcm_q && !zero_case;
    // A zero operand can only be seen before any common factor was counted, so k_q is 0 then.
    assign g_val     = (a_q == '0 ? b_q : a_q) << k_q;

    // NOTE: every clocked register uses <= so all of them update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_GCD;
            S_GCD: begin
                busy = 1'b1;
                if (gcd_fin) state_d = to_div ? S_DIV : S_DONE;
            end
            S_DIV: begin
                busy = 1'b1;
                if (div_fin) state_d = S_MUL;
            end
            S_MUL: begin
                busy = 1'b1;
                if (mul_fin) state_d = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_d = S_GCD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lcm_q <= 1'b0;
            opa_q <= '0;
            opb_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            g_q   <= '0;
            k_q   <= '0;
        end else if (accept) begin
            lcm_q <= (LCM_EN != 0) && mode;
            opa_q <= op_a;
            opb_q <= op_b;
            a_q   <= op_a;
            b_q   <= op_b;
            k_q   <= '0;
        end else if (state_q == S_GCD) begin
            if (gcd_fin) begin
                g_q <= g_val;
            end else if (!a_q[0] && !b_q[0]) begin
                a_q <= a_q >> 1;
                b_q <= b_q >> 1;
                k_q <= k_q + KW'(1);
            end else if (!a_q[0]) begin
                a_q <= a_q >> 1;
            end else if (!b_q[0]) begin
                b_q <= b_q >> 1;
            end else if (a_q > b_q) begin
                // Difference of two odd values is even, so the halving is folded in.
                a_q <= (a_q - b_q) >> 1;
            end else begin
                b_q <= (b_q - a_q) >> 1;
            end
        end
    end

    generate
        if (LCM_EN != 0) begin : g_lcm
            logic [WIDTH-1:0]   rem_q, quo_q;
            logic [2*WIDTH-1:0] prod_q;
            logic [CW-1:0]      cnt_q;
            logic [WIDTH:0]     rem_sh, rem_diff, sum;
            logic               fits, last;

            always_comb begin
                rem_sh   = {rem_q, quo_q[WIDTH-1]};
                rem_diff = rem_sh - {1'b0, g_q};
                fits     = rem_sh >= {1'b0, g_q};
                sum      = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opb_q} : '0);
            end

            assign last     = (cnt_q == CW'(WIDTH - 1));
            assign div_fin  = (state_q == S_DIV) && last;
            assign mul_fin  = (state_q == S_MUL) && last;
            assign lcm_prod = {sum, prod_q[WIDTH-1:1]};

            always_ff @(posedge clk) begin
                if (reset) begin
                    rem_q  <= '0;
                    quo_q  <= '0;
                    prod_q <= '0;
                    cnt_q  <= '0;
                end else if (gcd_fin) begin
                    rem_q  <= '0;
                    quo_q  <= opa_q;
                    cnt_q  <= '0;
                end else if (state_q == S_DIV) begin
                    rem_q  <= fits ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                    quo_q  <= {quo_q[WIDTH-2:0], fits};
                    cnt_q  <= last ? '0 : cnt_q + CW'(1);
                    // Multiplier register starts as {0, quotient}; product bits shift in from the top.
                    if (last) prod_q <= {{WIDTH{1'b0}}, quo_q[WIDTH-2:0], fits};
                end else if (state_q == S_MUL) begin
                    prod_q <= lcm_prod;
                    cnt_q  <= last ? '0 : cnt_q + CW'(1);
                end
            end
        end else begin : g_no_lcm
            assign div_fin  = 1'b0;
            assign mul_fin  = 1'b0;
            assign lcm_prod = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || accept) begin
            result_q    <= '0;
            result_hi_q <= '0;
            overflow_q  <= 1'b0;
        end else if (gcd_fin && !to_div) begin
            result_q    <= lcm_q ? '0 : g_val;
        end else if (mul_fin) begin
            result_q    <= lcm_prod[WIDTH-1:0];
            result_hi_q <= lcm_prod[2*WIDTH-1:WIDTH];
            overflow_q  <= |lcm_prod[2*WIDTH-1:WIDTH];
        end
    end

    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_gcd_lcm_cop.sv
// Directed bench for gcd_lcm_cop: 8-bit full, 8-bit GCD-only and 32-bit instances.
`timescale 1ns/1ps
module tb_gcd_lcm_cop;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        st8, m8;
    logic [7:0]  a8, b8;
    logic        bz8, dn8, ov8, bzn, dnn, ovn;
    logic [7:0]  r8, rh8, rn, rhn;
    logic        st32, m32;
    logic [31:0] a32, b32, r32, rh32;
    logic        bz32, dn32, ov32;

    int n_pass  = 0;
    int n_total = 0;

    gcd_lcm_cop #(.WIDTH(8), .LCM_EN(1)) dut8 (
        .clk(clk), .reset(reset), .start(st8), .mode(m8), .op_a(a8), .op_b(b8),
        .busy(bz8), .done(dn8), .result(r8), .result_hi(rh8), .overflow(ov8)
    );

    gcd_lcm_cop #(.WIDTH(8), .LCM_EN(0)) dutn (
        .clk(clk), .reset(reset), .start(st8), .mode(m8), .op_a(a8), .op_b(b8),
        .busy(bzn), .done(dnn), .result(rn), .result_hi(rhn), .overflow(ovn)
    );

    gcd_lcm_cop #(.WIDTH(32), .LCM_EN(1)) dut32 (
        .clk(clk), .reset(reset), .start(st32), .mode(m32), .op_a(a32), .op_b(b32),
        .busy(bz32), .done(dn32), .result(r32), .result_hi(rh32), .overflow(ov32)
    );

    function automatic logic done_of(input int sel);
        case (sel)
            0:       return dn8;
            1:       return dnn;
            default: return dn32;
        endcase
    endfunction

    // Holds start for one edge (the acceptance edge) and returns #1 after it.
    task automatic issue(input int sel, input logic m, input logic [31:0] a, input logic [31:0] b);
        if (sel == 2) begin
            m32 = m; a32 = a; b32 = b; st32 = 1'b1;
        end else begin
            m8 = m; a8 = a[7:0]; b8 = b[7:0]; st8 = 1'b1;
        end
        @(posedge clk); #1;
        st8  = 1'b0;
        st32 = 1'b0;
    endtask

    // Counts edges until done; returns limit+1 if done never rises.
    task automatic wait_done(input int sel, input int limit, output int cycles);
        cycles = 0;
        while (!done_of(sel) && cycles <= limit) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        m8 = 1'b1; a8 = 8'd5; b8 = 8'd5; st8 = 1'b1;
        st32 = 1'b1; m32 = 1'b0; a32 = 32'd7; b32 = 32'd7;
        repeat (2) begin @(posedge clk); #1; end
        n_total++;
        if ({bz8, dn8, r8, rh8, ov8} !== 19'd0)
            $display("FAIL reset_w8 got %b want all zero", {bz8, dn8, r8, rh8, ov8});
        else n_pass++;
        n_total++;
        if ({bzn, dnn, rn, rhn, ovn} !== 19'd0)
            $display("FAIL reset_gcdonly got %b want all zero", {bzn, dnn, rn, rhn, ovn});
        else n_pass++;
        n_total++;
        if ({bz32, dn32, r32, rh32, ov32} !== 67'd0)
            $display("FAIL reset_w32 got busy=%b done=%b res=%h hi=%h ovf=%b want all zero",
                     bz32, dn32, r32, rh32, ov32);
        else n_pass++;
        reset = 1'b0;
        st8   = 1'b0;
        st32  = 1'b0;
    endtask

    task automatic test_gcd;
        int cyc;
        issue(0, 1'b0, 32'd48, 32'd18);
        n_total++;
        if ({bz8, dn8} !== 2'b10) $display("FAIL gcd_accept busy,done=%b want 10", {bz8, dn8});
        else n_pass++;
        wait_done(0, 36, cyc);
        n_total++;
        if (cyc > 36) $display("FAIL gcd48_18_latency got %0d cycles want <=36", cyc);
        else n_pass++;
        n_total++;
        if ({r8, rh8, ov8} !== {8'd6, 8'd0, 1'b0})
            $display("FAIL gcd48_18 got res=%0d hi=%0d ovf=%b want 6 0 0", r8, rh8, ov8);
        else n_pass++;
        repeat (3) begin @(posedge clk); #1; end
        n_total++;
        if ({bz8, dn8, r8} !== {1'b0, 1'b1, 8'd6})
            $display("FAIL done_hold got busy=%b done=%b res=%0d want 0 1 6", bz8, dn8, r8);
        else n_pass++;
        issue(0, 1'b0, 32'd36, 32'd24);
        wait_done(0, 36, cyc);
        n_total++;
        if ({r8, cyc <= 36} !== {8'd12, 1'b1})
            $display("FAIL gcd36_24 got res=%0d cycles=%0d want 12 within 36", r8, cyc);
        else n_pass++;
    endtask

    task automatic test_lcm;
        int cyc;
        issue(0, 1'b1, 32'd4, 32'd6);
        wait_done(0, 56, cyc);
        n_total++;
        if (cyc > 56) $display("FAIL lcm4_6_latency got %0d cycles want <=56", cyc);
        else n_pass++;
        n_total++;
        if ({r8, rh8, ov8} !== {8'd12, 8'd0, 1'b0})
            $display("FAIL lcm4_6 got res=%0d hi=%0d ovf=%b want 12 0 0", r8, rh8, ov8);
        else n_pass++;
        issue(0, 1'b1, 32'd12, 32'd18);
        wait_done(0, 56, cyc);
        n_total++;
        if ({r8, rh8, ov8, cyc <= 56} !== {8'd36, 8'd0, 1'b0, 1'b1})
            $display("FAIL lcm12_18 got res=%0d hi=%0d ovf=%b cycles=%0d want 36 0 0", r8, rh8, ov8, cyc);
        else n_pass++;
    endtask

    task automatic test_overflow;
        int cyc;
        issue(0, 1'b1, 32'd200, 32'd3);
        wait_done(0, 56, cyc);
        n_total++;
        if ({r8, rh8, ov8, cyc <= 56} !== {8'd88, 8'd2, 1'b1, 1'b1})
            $display("FAIL lcm200_3 got res=%0d hi=%0d ovf=%b cycles=%0d want 88 2 1", r8, rh8, ov8, cyc);
        else n_pass++;
    endtask

    task automatic test_zeros;
        int cyc;
        issue(0, 1'b0, 32'd0, 32'd0);
        wait_done(0, 2, cyc);
        n_total++;
        if ({r8, rh8, ov8, cyc <= 2} !== {8'd0, 8'd0, 1'b0, 1'b1})
            $display("FAIL gcd0_0 got res=%0d cycles=%0d want 0 within 2", r8, cyc);
        else n_pass++;
        issue(0, 1'b0, 32'd0, 32'd9);
        wait_done(0, 2, cyc);
        n_total++;
        if ({r8, rh8, ov8, cyc <= 2} !== {8'd9, 8'd0, 1'b0, 1'b1})
            $display("FAIL gcd0_9 got res=%0d cycles=%0d want 9 within 2", r8, cyc);
        else n_pass++;
        issue(0, 1'b1, 32'd0, 32'd5);
        wait_done(0, 2, cyc);
        n_total++;
        if ({r8, rh8, ov8, cyc <= 2} !== {8'd0, 8'd0, 1'b0, 1'b1})
            $display("FAIL lcm0_5 got res=%0d hi=%0d ovf=%b cycles=%0d want 0 0 0 within 2",
                     r8, rh8, ov8, cyc);
        else n_pass++;
        issue(0, 1'b0, 32'd7, 32'd0);
        wait_done(0, 2, cyc);
        n_total++;
        if ({r8, cyc <= 2} !== {8'd7, 1'b1})
            $display("FAIL gcd7_0 got res=%0d cycles=%0d want 7 within 2", r8, cyc);
        else n_pass++;
    endtask

    task automatic test_ignore_start;
        int cyc;
        issue(0, 1'b1, 32'd4, 32'd6);
        repeat (2) begin @(posedge clk); #1; end
        m8 = 1'b0; a8 = 8'd200; b8 = 8'd3; st8 = 1'b1;
        @(posedge clk); #1;
        st8 = 1'b0;
        n_total++;
        if (bz8 !== 1'b1) $display("FAIL ignore_busy got busy=%b want 1", bz8);
        else n_pass++;
        wait_done(0, 56, cyc);
        n_total++;
        if ({r8, rh8, ov8, cyc <= 56} !== {8'd12, 8'd0, 1'b0, 1'b1})
            $display("FAIL ignore_result got res=%0d hi=%0d ovf=%b cycles=%0d want 12 0 0", r8, rh8, ov8, cyc);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int cyc;
        issue(0, 1'b0, 32'd48, 32'd18);
        n_total++;
        if ({bz8, dn8, r8} !== {1'b1, 1'b0, 8'd0})
            $display("FAIL b2b_restart got busy=%b done=%b res=%0d want 1 0 0", bz8, dn8, r8);
        else n_pass++;
        wait_done(0, 36, cyc);
        n_total++;
        if ({r8, rh8, ov8, cyc <= 36} !== {8'd6, 8'd0, 1'b0, 1'b1})
            $display("FAIL b2b_result got res=%0d cycles=%0d want 6 within 36", r8, cyc);
        else n_pass++;
    endtask

    task automatic test_lcm_disabled;
        int cyc;
        issue(0, 1'b1, 32'd4, 32'd6);
        wait_done(1, 36, cyc);
        n_total++;
        if ({rn, rhn, ovn, cyc <= 36} !== {8'd2, 8'd0, 1'b0, 1'b1})
            $display("FAIL gcdonly_mode1 got res=%0d hi=%0d ovf=%b cycles=%0d want 2 0 0", rn, rhn, ovn, cyc);
        else n_pass++;
        wait_done(0, 56, cyc);
        n_total++;
        if (r8 !== 8'd12) $display("FAIL lcm_side_by_side got res=%0d want 12", r8);
        else n_pass++;
    endtask

    task automatic test_reset_mid_lcm;
        int cyc;
        issue(2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        repeat (10) begin @(posedge clk); #1; end
        n_total++;
        if (bz32 !== 1'b1) $display("FAIL mid_lcm_busy got busy=%b want 1", bz32);
        else n_pass++;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_total++;
        if ({bz32, dn32, r32, rh32, ov32} !== 67'd0)
            $display("FAIL mid_lcm_reset got busy=%b done=%b res=%h hi=%h ovf=%b want all zero",
                     bz32, dn32, r32, rh32, ov32);
        else n_pass++;
        issue(2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        wait_done(2, 200, cyc);
        n_total++;
        if (cyc > 200) $display("FAIL lcm32_latency got %0d cycles want <=200", cyc);
        else n_pass++;
        n_total++;
        if ({r32, rh32, ov32} !== {32'h0000_0002, 32'hFFFF_FFFD, 1'b1})
            $display("FAIL lcm32 got res=%h hi=%h ovf=%b want 00000002 fffffffd 1", r32, rh32, ov32);
        else n_pass++;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_total++;
        if ({bz32, dn32, r32, rh32, ov32} !== 67'd0)
            $display("FAIL done_reset got busy=%b done=%b res=%h hi=%h ovf=%b want all zero",
                     bz32, dn32, r32, rh32, ov32);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        st8 = 1'b0; m8 = 1'b0; a8 = '0; b8 = '0;
        st32 = 1'b0; m32 = 1'b0; a32 = '0; b32 = '0;
        test_reset;
        test_gcd;
        test_lcm;
        test_overflow;
        test_zeros;
        test_ignore_start;
        test_back_to_back;
        test_lcm_disabled;
        test_reset_mid_lcm;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/gcd_lcm_cop.md
GCD_LCM_COP -- requirements
Module: gcd_lcm_cop

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (legal range 4..64).
REQ-002 SHALL have parameter LCM_EN, default 1, meaning LCM mode is present (0: mode ignored, GCD only).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to begin an operation.
REQ-006 SHALL have port mode  input  1  0 = GCD, 1 = LCM; sampled with start.
REQ-007 SHALL have ports op_a, op_b  input  WIDTH  unsigned operands; sampled with start.
REQ-008 SHALL have port busy  output  1  operation in progress.
REQ-009 SHALL have port done  output  1  result valid; level, not pulse.
REQ-010 SHALL have port result  output  WIDTH  GCD, or low WIDTH bits of LCM.
REQ-011 SHALL have port result_hi  output  WIDTH  upper WIDTH bits of LCM; 0 in GCD mode.
REQ-012 SHALL have port overflow  output  1  LCM exceeds WIDTH bits (result_hi != 0).

Function
REQ-013 SHALL implement states IDLE, GCD, DIV, MUL, DONE.
REQ-014 SHALL accept start only in IDLE or DONE: latch op_a, op_b, mode; clear done/overflow; enter GCD; busy=1 from the next cycle.
REQ-015 SHALL ignore start while busy=1: no relatch, no restart, current operation unaffected.
REQ-016 SHALL compute GCD by binary (Stein) algorithm, one step per cycle: shift out common factors of 2 (count k), strip remaining factors of 2, subtract smaller from larger until equal or zero, then restore the k common factors by shifting left.
REQ-017 SHALL complete GCD mode in at most 4*WIDTH+4 cycles from start acceptance to done=1.
REQ-018 SHALL, in LCM mode, after GCD g, compute q = op_a / g by restoring shift-subtract division (WIDTH cycles, DIV), then product = q * op_b by shift-add (WIDTH cycles, MUL) into a 2*WIDTH accumulator.
REQ-019 SHALL complete LCM mode in at most 6*WIDTH+8 cycles from start acceptance.
REQ-020 SHALL drive result = product[WIDTH-1:0], result_hi = product[2*WIDTH-1:WIDTH], overflow = |result_hi in LCM mode.
REQ-021 SHALL treat zeros: gcd(0,b)=b, gcd(a,0)=a, gcd(0,0)=0; lcm with any zero operand = 0, overflow=0; zero cases skip DIV/MUL and reach DONE within 2 cycles.
REQ-022 SHALL, on entering DONE, set busy=0, done=1, and hold result/result_hi/overflow stable until the next accepted start or reset.
REQ-023 SHALL, if start is high in the DONE cycle, begin the new operation (done falls next cycle); back-to-back operations are legal.
REQ-024 SHALL treat mode as 0 when LCM_EN=0; DIV/MUL logic SHALL NOT be generated.
REQ-025 SHALL never divide by zero: DIV entered only when g != 0.

Reset
REQ-026 SHALL, when reset=1 at a clock edge, enter IDLE and drive busy=0, done=0, result=0, result_hi=0, overflow=0.
REQ-027 SHALL abort any operation in progress on reset, discarding partial state; start asserted with reset SHALL be ignored.
REQ-028 SHALL accept a start in the first cycle after reset deasserts.

Verification (WIDTH=8 unless noted)
REQ-029 SHALL cover: mode=0, a=48, b=18 -> done within 36 cycles, result=6, result_hi=0, overflow=0.
REQ-030 SHALL cover: mode=1, a=4, b=6 -> result=12, result_hi=0, overflow=0 within 56 cycles.
REQ-031 SHALL cover: mode=1, a=200, b=3 -> result=88, result_hi=2, overflow=1.
REQ-032 SHALL cover: zeros: gcd(0,0)=0, gcd(0,9)=9, lcm(0,5)=0 each with done within 2 cycles of acceptance.
REQ-033 SHALL cover: start pulsed mid-operation with different operands -> ignored, original result returned; then start in DONE cycle -> second result correct.
REQ-034 SHALL cover: reset asserted mid-LCM -> next cycle busy=0, done=0, outputs 0; following start with WIDTH=32, a=0xFFFFFFFF, b=0xFFFFFFFE, mode=1 -> result=0x00000002, result_hi=0xFFFFFFFD, overflow=1.
